// File: rtl/assoc_cache.sv
// 2-way set-associative write-through data cache with LRU replacement and beat-wise block refill.
// Define CACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module assoc_cache #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned SETS            = 4,
  parameter int unsigned WORDS_PER_BLOCK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  byte_addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int unsigned OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [OFF_W-1:0]        beat_q, beat_d;
  logic                    victim_q, victim_d;
  logic [SETS-1:0]         valid_q [2];
  logic [SETS-1:0]         lru_q;
  logic [TAG_W-1:0]        tag_q   [2][SETS];
  logic [DATA_WIDTH-1:0]   data_q  [2][SETS][WORDS_PER_BLOCK];

  logic [1:0]              byte_sel;
  logic [OFF_W-1:0]        off;
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [1:0]              way_hit;
  logic                    lookup_hit;
  logic                    hit_way;
  logic [DATA_WIDTH-1:0]   word;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [3:0]              wr_be;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   merged;

  logic start_refill, fill_beat, fill_done, rd_hit, wr_hit_upd;

  assign byte_sel = addr[1:0];
  assign off      = addr[2 +: OFF_W];
  assign idx      = addr[2 + OFF_W +: IDX_W];
  assign tag      = addr[TAG_LSB +: TAG_W];

  // Tag compare across both ways of the addressed set
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
  end

  assign lookup_hit = |way_hit;
  assign hit_way    = way_hit[1];
  assign word       = data_q[hit_way][idx][off];
  assign load_data  = byte_addr ? DATA_WIDTH'(word[{byte_sel, 3'b000} +: 8]) : word;
  assign wr_be      = byte_addr ? 4'(4'b0001 << byte_sel) : 4'b1111;
  assign wr_word    = byte_addr ? {4{wdata[7:0]}} : wdata;

  always_comb begin
    merged = word;
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) merged[8*b +: 8] = wr_word[8*b +: 8];
    end
  end

  // Next-state and output decode; reset forces the request-facing outputs low
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    victim_d     = victim_q;
    hit          = 1'b0;
    stall        = 1'b0;
    rdata        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {addr[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata    = wr_word;
    mem_be       = wr_be;
    start_refill = 1'b0;
    fill_beat    = 1'b0;
    fill_done    = 1'b0;
    rd_hit       = 1'b0;
    wr_hit_upd   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr) begin
          stall   = 1'b1;
          state_d = S_WRITE;
        end else if (rd) begin
          if (lookup_hit) begin
            hit    = 1'b1;
            rdata  = load_data;
            rd_hit = 1'b1;
          end else begin
            stall        = 1'b1;
            start_refill = 1'b1;
            state_d      = S_REFILL;
            victim_d     = !valid_q[0][idx] ? 1'b0 :
                           (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
          end
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        stall    = 1'b1;
        mem_addr = {addr[ADDR_WIDTH-1:2+OFF_W], beat_q, 2'b00};
        if (mem_ready) begin
          fill_beat = 1'b1;
          beat_d    = beat_q + OFF_W'(1);
          if (beat_q == OFF_W'(WORDS_PER_BLOCK - 1)) begin
            fill_done = 1'b1;
            beat_d    = '0;
            state_d   = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        stall   = ~mem_ready;
        if (mem_ready) begin
          wr_hit_upd = lookup_hit;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      hit          = 1'b0;
      stall        = 1'b0;
      rdata        = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      start_refill = 1'b0;
      fill_beat    = 1'b0;
      fill_done    = 1'b0;
      rd_hit       = 1'b0;
      wr_hit_upd   = 1'b0;
    end
  end

  // Victim is invalidated at refill start so an abandoned refill never leaves a stale line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      victim_q   <= 1'b0;
      lru_q      <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      victim_q <= victim_d;
      if (start_refill) valid_q[victim_d][idx] <= 1'b0;
      if (fill_done)    valid_q[victim_q][idx] <= 1'b1;
      if (rd_hit || wr_hit_upd) lru_q[idx] <= ~hit_way;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat)  data_q[victim_q][idx][beat_q] <= mem_rdata;
    if (fill_done)  tag_q[victim_q][idx] <= tag;
    if (wr_hit_upd) data_q[hit_way][idx][off] <= merged;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        after_refill_q;

  // The replayed lookup that completes a miss is not counted as a hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      after_refill_q <= 1'b0;
    end else begin
      after_refill_q <= fill_done;
      if (rd_hit && !after_refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (start_refill)              miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/assoc_cache.md
Name: assoc_cache

Overview:
- Parametrised 2-way set-associative data cache with LRU replacement, placed between the load/store unit and data memory.
- Successor to the direct-mapped, 4-set, single-cycle cache.
- Adds a configurable set count and block size, and a refill state machine that fetches a block one word per beat over a ready-handshake memory port.
- Write-through, no-write-allocate; byte-lane aware reads and writes.

Parameters:
- DATA_WIDTH, 32, word width in bits (fixed at 32 for byte-lane logic).
- ADDR_WIDTH, 32, byte address width.
- SETS, 4, number of sets; power of 2, ≥2.
- WORDS_PER_BLOCK, 4, words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd  in  1  load request, held until stall low.
- wr  in  1  store request, held until stall low.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data.
- byte_addr  in  1  1 = byte access, 0 = word access.
- rdata  out  DATA_WIDTH  load data.
- hit  out  1  lookup hit (combinational, IDLE only).
- stall  out  1  request not yet complete.
- mem_req  out  1  memory transaction valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_be  out  4  write byte enables.
- mem_ready  in  1  memory accepts/completes current beat.
- mem_rdata  in  DATA_WIDTH  read beat data.

Behaviour:
- Address split: addr[1:0] byte, next log2(WORDS_PER_BLOCK) bits word offset, next log2(SETS) bits set index, remainder tag.
- Per set: 2 ways of {valid, tag, block}, plus 1 LRU bit naming the least-recently-used way.
- Reset: all valid and LRU bits 0, FSM to IDLE, beat counter 0. mem_req, mem_we, stall, hit, rdata are 0 while rst is high.
- Reset during REFILL abandons the refill; the victim line stays invalid.
- States: IDLE, REFILL, WRITE.
- IDLE, rd hit:
  - hit=1, stall=0, rdata driven combinationally the same cycle.
  - Word access returns the full word; byte access returns the zero-extended byte selected by addr[1:0].
  - LRU set to the other way at the clock edge.
- IDLE, rd miss:
  - stall=1; go to REFILL.
  - Victim: first invalid way (way0 before way1), else the LRU way. Victim is latched on entry to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, stall=1.
  - mem_addr = block base + 4*beat.
  - On mem_ready, mem_rdata is written to victim word[beat] and beat increments.
  - After the beat WORDS_PER_BLOCK-1 handshake: victim valid=1 and tag written, beat=0, back to IDLE.
  - The next cycle hits, so minimum miss latency is WORDS_PER_BLOCK+1 cycles.
- IDLE, wr: stall=1; go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = addr with [1:0] cleared.
  - Word access: mem_be=4'b1111, mem_wdata=wdata.
  - Byte access: mem_be one-hot on addr[1:0], and wdata[7:0] replicated to all lanes.
  - stall = ~mem_ready.
  - On mem_ready, if the line hits, the cached word is updated on enabled lanes only and LRU is updated. Return to IDLE.
  - On a write miss, the cache is not modified.
- rd and wr both high: wr takes priority; rd is ignored for that request.
- In IDLE with no request: mem_req=0, stall=0, hit=0.
- mem_addr, mem_wdata, mem_be are don't-care when mem_req=0.
- Inputs addr, wdata, byte_addr must be stable while stall=1; the bench checks this as an assertion.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per completed rd hit.
  - miss_count increments once per IDLE→REFILL transition.
  - Write hits/misses are not counted; counters wrap at 2^32.
- CACHE_STATS_EN undefined: ports and counters are absent; no other behaviour changes.

Test Plan:
- Reset, rd addr=0x40 (memory beats return 0xA0,0xA1,0xA2,0xA3 with mem_ready every cycle) -> 4 reads at 0x40,0x44,0x48,0x4C; stall high 5 cycles; then hit=1, rdata=0xA0. rd 0x4C -> same-cycle hit, rdata=0xA3.
- SETS=4, WORDS_PER_BLOCK=4: fill 0x000 and 0x040 (same set), read 0x000, then read 0x080 -> way holding 0x040 evicted; reread 0x000 hits, 0x040 misses.
- Byte read at 0x41 after line filled with word 0x11223344 at 0x40 -> rdata=0x00000033.
- wr byte_addr=1, addr=0x42, wdata=0xFF on a cached line, mem_ready delayed 3 cycles -> mem_be=4'b0100, stall high 3 cycles; subsequent rd 0x40 returns 0x11FF3344. wr to an uncached address -> memory write only; next rd misses.
- Assert rst in the second refill beat -> mem_req drops immediately; after release, rd same address misses and refills fully.
- With CACHE_STATS_EN: the sequence 1 miss + 3 hits -> miss_count=1, hit_count=3.
